flag_verdict: RTL and testbench

Streaming verdict stage directly downstream of the four-stage `magic` transform chain. It consumes one transformed byte per accepted beat from the chain's `res` output and compares each against a fixed expected-byte table. It fails fast on the first mismatch or on a stalled stream, and holds a sticky pass/fail verdict until the next `start`. It is the block that turns the transform pipeline into a complete checker.

---
 rtl/flag_pkg.sv | 28 ++
 rtl/flag_gap_timer.sv | 45 ++++
 rtl/flag_verdict.sv | 111 +++++++++++
 tb/tb_flag_verdict.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared definitions for the flag verdict stage: expected transform outputs and FSM states.
package flag_pkg;

  localparam int FLAG_LEN_DEFAULT = 32;
  localparam int EXP_AW = $clog2(FLAG_LEN_DEFAULT);

  // Required outputs of the last magic stage, ASCII "flag{m4g1c_ch41n_v3rd1ct_0k_42!}"
  localparam logic [7:0] EXPECTED [FLAG_LEN_DEFAULT] = '{
    8'h66, 8'h6c, 8'h61, 8'h67, 8'h7b, 8'h6d, 8'h34, 8'h67,
    8'h31, 8'h63, 8'h5f, 8'h63, 8'h68, 8'h34, 8'h31, 8'h6e,
    8'h5f, 8'h76, 8'h33, 8'h72, 8'h64, 8'h31, 8'h63, 8'h74,
    8'h5f, 8'h30, 8'h6b, 8'h5f, 8'h34, 8'h32, 8'h21, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } verdict_state_t;

  // Positions past the table compare against zero rather than wrapping.
  function automatic logic [7:0] expected_at(int i);
    if (i >= 0 && i < FLAG_LEN_DEFAULT) return EXPECTED[i[EXP_AW-1:0]];
    return 8'h00;
  endfunction

endpackage

// File: rtl/flag_gap_timer.sv
// Saturating idle-cycle counter; expired pulses on the tick that completes TIMEOUT idle cycles.
module flag_gap_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, tick};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (tick && (cnt_q != SAT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired = tick && !clear && (cnt_q >= LAST);
    end
  endgenerate

endmodule

// File: rtl/flag_verdict.sv
// Streaming verdict stage: compares each accepted transform byte with the expected table
// and holds a sticky pass/fail result until the next start.
module flag_verdict
  import flag_pkg::*;
#(
  parameter int FLAG_LEN = FLAG_LEN_DEFAULT,
  parameter int TIMEOUT  = 64,
  parameter int IW       = $clog2(FLAG_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          res_valid,
  input  logic [7:0]    res,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [IW-1:0] idx,
  output logic [IW-1:0] fail_idx
);

  // IDLE: no check yet | RUN: comparing bytes | PASS/FAIL: sticky verdict until start

  verdict_state_t state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  fidx_q, fidx_d;
  logic           tmo_q, tmo_d;

  logic           running;
  logic           match;
  logic           last_byte;
  logic [IW-1:0]  idx_inc;
  logic           gap_clear;
  logic           gap_tick;
  logic           gap_expired;

  assign running   = (state_q == RUN);
  assign idx_inc   = idx_q + 1'b1;
  assign last_byte = (idx_inc == IW'(FLAG_LEN));
  assign match     = (res == expected_at(int'(idx_q)));

  // Any cycle outside RUN or any accepted byte restarts the gap measurement.
  assign gap_clear = !running || res_valid;
  assign gap_tick  = running && !res_valid;

  flag_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (gap_clear),
    .tick    (gap_tick),
    .expired (gap_expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fidx_d  = fidx_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE, PASS, FAIL: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          fidx_d  = '0;
          tmo_d   = 1'b0;
        end
      end
      RUN: begin
        if (res_valid) begin
          idx_d = idx_inc;
          if (!match) begin
            state_d = FAIL;
            fidx_d  = idx_q;
          end else if (last_byte) begin
            state_d = PASS;
          end
        end else if (gap_expired) begin
          state_d = FAIL;
          tmo_d   = 1'b1;
          fidx_d  = idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fidx_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fidx_q  <= fidx_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy     = running;
  assign done     = (state_q == PASS) || (state_q == FAIL);
  assign pass     = (state_q == PASS);
  assign timeout  = tmo_q;
  assign idx      = idx_q;
  assign fail_idx = fidx_q;

endmodule

// File: tb/tb_flag_verdict.sv
// Scoreboard bench for flag_verdict: stimulus queues expectations, monitors compare them.
module tb_flag_verdict;

  localparam int FLAG_LEN = 32;
  localparam int TIMEOUT  = 64;
  localparam int IW       = $clog2(FLAG_LEN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          res_valid = 1'b0;
  logic [7:0]    res = 8'h00;
  logic          busy, done, pass, timeout;
  logic [IW-1:0] idx, fail_idx;

  flag_verdict #(
    .FLAG_LEN (FLAG_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .res_valid (res_valid),
    .res       (res),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .idx       (idx),
    .fail_idx  (fail_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string         name;
    int            due;
    logic          busy;
    logic          done;
    logic          pass;
    logic          tmo;
    logic [IW-1:0] idx;
    logic [IW-1:0] fidx;
  } exp_t;

  exp_t vq[$];   // verdicts, checked when done rises
  exp_t pq[$];   // probes, checked at their due edge
  exp_t rq[$];   // checked just after rst rises

  int passed = 0;
  int total  = 0;

  string flag_s = "flag{m4g1c_ch41n_v3rd1ct_0k_42!}";

  function automatic logic [7:0] xb(int i);
    return flag_s[i];
  endfunction

  function automatic exp_t mk(string n, int due, logic b, logic d, logic p, logic t,
                              int i, int f);
    exp_t e;
    e.name = n;
    e.due  = due;
    e.busy = b;
    e.done = d;
    e.pass = p;
    e.tmo  = t;
    e.idx  = IW'(i);
    e.fidx = IW'(f);
    return e;
  endfunction

  task automatic check(input exp_t e, input bit timing_ok);
    logic [3+2*IW:0] act, req;
    act = {busy, done, pass, timeout, idx, fail_idx};
    req = {e.busy, e.done, e.pass, e.tmo, e.idx, e.fidx};
    total++;
    if (act === req && timing_ok) begin
      passed++;
    end else begin
      $display("FAIL %s: at cycle %0d (due %0d) busy/done/pass/timeout/idx/fail_idx = %b/%b/%b/%b/%0d/%0d, required %b/%b/%b/%b/%0d/%0d",
               e.name, cyc, e.due, busy, done, pass, timeout, idx, fail_idx,
               e.busy, e.done, e.pass, e.tmo, e.idx, e.fidx);
    end
  endtask

  initial begin : verdict_and_probe_monitor
    exp_t e;
    logic done_d;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_d !== 1'b1) begin
        if (vq.size() == 0) begin
          total++;
          $display("FAIL unexpected_verdict: done rose at cycle %0d with no verdict expected", cyc);
        end else begin
          e = vq.pop_front();
          check(e, cyc == e.due);
        end
      end
      done_d = done;
      while (pq.size() > 0 && pq[0].due <= cyc) begin
        e = pq.pop_front();
        check(e, cyc == e.due);
      end
    end
  end

  initial begin : reset_monitor
    exp_t e;
    forever begin
      @(posedge rst);
      #1;
      if (rq.size() > 0) begin
        e = rq.pop_front();
        check(e, 1'b1);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic s, input logic v, input logic [7:0] b);
    start     = s;
    res_valid = v;
    res       = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic feed(input int from, input int upto);
    for (int i = from; i <= upto; i++) step(1'b0, 1'b1, xb(i));
  endtask

  initial begin : stimulus
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    pq.push_back(mk("reset_state", cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    idle(1);
    pq.push_back(mk("idle_ignores_valid", cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    step(1'b0, 1'b1, xb(0));

    // Full match at one byte per cycle
    pq.push_back(mk("start_enters_run", cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
    step(1'b1, 1'b0, 8'h00);
    pq.push_back(mk("mid_run_idx16", cyc + 16, 1'b1, 1'b0, 1'b0, 1'b0, 16, 0));
    feed(0, 15);
    vq.push_back(mk("full_match", cyc + 16, 1'b0, 1'b1, 1'b1, 1'b0, 32, 0));
    feed(16, 31);
    idle(2);

    // Restart from PASS with a coincident byte, then start pulsed mid-run
    pq.push_back(mk("restart_from_pass", cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
    step(1'b1, 1'b1, xb(0));
    pq.push_back(mk("restart_byte_dropped", cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
    idle(1);
    feed(0, 4);
    pq.push_back(mk("start_mid_run_ignored", cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 6, 0));
    step(1'b1, 1'b1, xb(5));
    feed(6, 9);

    // Asynchronous reset between edges at idx 10
    #2;
    rq.push_back(mk("async_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pq.push_back(mk("post_reset_valid_ignored", cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
    step(1'b0, 1'b1, xb(0));

    // Early mismatch and trailing beats
    step(1'b1, 1'b0, 8'h00);
    feed(0, 4);
    vq.push_back(mk("early_mismatch", cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 6, 5));
    step(1'b0, 1'b1, xb(5) ^ 8'h01);
    pq.push_back(mk("trailing_beats_ignored", cyc + 3, 1'b0, 1'b1, 1'b0, 1'b0, 6, 5));
    repeat (3) step(1'b0, 1'b1, xb(6));

    // Restart from FAIL, mismatch on the very first byte
    pq.push_back(mk("restart_from_fail", cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
    step(1'b1, 1'b0, 8'h00);
    vq.push_back(mk("mismatch_first_byte", cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0));
    step(1'b0, 1'b1, ~xb(0));

    // Stall after three good bytes
    step(1'b1, 1'b0, 8'h00);
    feed(0, 2);
    pq.push_back(mk("stall_still_run_at_63", cyc + 63, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0));
    vq.push_back(mk("stall_timeout", cyc + 64, 1'b0, 1'b1, 1'b0, 1'b1, 3, 3));
    idle(70);

    // A byte on idle cycle 63 keeps RUN and restarts the gap timer
    pq.push_back(mk("restart_clears_timeout", cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
    step(1'b1, 1'b0, 8'h00);
    feed(0, 2);
    idle(62);
    pq.push_back(mk("byte_on_cycle63_keeps_run", cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0));
    step(1'b0, 1'b1, xb(3));
    vq.push_back(mk("second_stall_timeout", cyc + 64, 1'b0, 1'b1, 1'b0, 1'b1, 4, 4));
    idle(68);

    while (vq.size() > 0) begin
      e = vq.pop_front();
      total++;
      $display("FAIL %s: verdict never observed, required at cycle %0d", e.name, e.due);
    end
    while (pq.size() > 0) begin
      e = pq.pop_front();
      total++;
      $display("FAIL %s: probe never evaluated, required at cycle %0d", e.name, e.due);
    end
    while (rq.size() > 0) begin
      e = rq.pop_front();
      total++;
      $display("FAIL %s: reset check never evaluated, required after rst rose", e.name);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
